// File: rtl/conv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_pkg                                                                 |
// | Shared FSM state encoding and width helpers for conv2d_stream_engine.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUTP = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Address/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Wide enough to hold KER*KER full-scale products without wrapping.
    function automatic int acc_width(input int data_w, input int ker);
        return 2 * data_w + $clog2(ker * ker);
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_mac_array                                                           |
// | LANES parallel multipliers, adder tree and clearable accumulator.        |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module conv_mac_array
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 3,
    parameter int ACC_W  = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [LANES*DATA_W-1:0] pix,
    input  logic [LANES*DATA_W-1:0] coef,
    output logic [ACC_W-1:0]        acc_sum
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_prod [LANES];
    logic [ACC_W-1:0] w_partial;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_prod[l] = ACC_W'(pix[l*DATA_W +: DATA_W]) * ACC_W'(coef[l*DATA_W +: DATA_W]);
    end

    always_comb begin
        w_partial = '0;
        for (int l = 0; l < LANES; l++) begin
            w_partial = w_partial + w_prod[l];
        end
    end

    // Running sum including the taps presented this cycle.
    assign acc_sum = r_acc + w_partial;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (clear) begin
            r_acc <= '0;
        end else if (enable) begin
            r_acc <= acc_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv2d_stream_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv2d_stream_engine                                                     |
// | Streaming 2-D true convolution with loadable image/kernel memories.      |
// | Build option: CONV_SAT_EN selects saturating instead of modulo results.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module conv2d_stream_engine
    import conv_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int IMG    = 4,
    parameter  int KER    = 3,
    parameter  int LANES  = 3,
    localparam int AW     = clog2_min1(IMG * IMG),
    localparam int OW     = clog2_min1(IMG - KER + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              load_sel,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              run,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OW-1:0]     out_row,
    output logic [OW-1:0]     out_col
);

    localparam int TAPS  = KER * KER;
    localparam int OUT   = IMG - KER + 1;
    localparam int ACC_W = acc_width(DATA_W, KER);
    localparam int KAW   = clog2_min1(TAPS);
    localparam int TW    = clog2_min1(TAPS);

    if ((TAPS % LANES) != 0) begin : g_lanes_check
        $error("conv2d_stream_engine: KER*KER must be a multiple of LANES");
    end

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [OW-1:0]       r_out_row;
    logic [OW-1:0]       r_out_col;
    logic [OW-1:0]       r_row;
    logic [OW-1:0]       r_col;
    logic [TW-1:0]       r_tap;

    logic [DATA_W-1:0]   r_img_mem [IMG*IMG];
    logic [DATA_W-1:0]   r_ker_mem [TAPS];

    logic [LANES*DATA_W-1:0] w_pix;
    logic [LANES*DATA_W-1:0] w_coef;
    logic [ACC_W-1:0]        w_acc_sum;
    logic [DATA_W-1:0]       w_result;
    logic                    w_clear;
    logic                    w_enable;
    logic                    w_last_group;
    logic                    w_last_pixel;

    // Memories carry no reset so contents survive both resets and runs.
    always_ff @(posedge clk) begin
        if (load_en && (r_state == ST_IDLE)) begin
            if (!load_sel && (int'(load_addr) < IMG * IMG)) begin
                r_img_mem[load_addr] <= load_data;
            end
            if (load_sel && (int'(load_addr) < TAPS)) begin
                r_ker_mem[KAW'(load_addr)] <= load_data;
            end
        end
    end

    // Kernel index TAPS-1-t realises the flip of true convolution.
    always_comb begin
        int t;
        int u;
        int v;
        t      = 0;
        u      = 0;
        v      = 0;
        w_pix  = '0;
        w_coef = '0;
        for (int l = 0; l < LANES; l++) begin
            t = int'(r_tap) + l;
            u = t / KER;
            v = t % KER;
            w_pix[l*DATA_W +: DATA_W]  = r_img_mem[AW'((int'(r_row) + u) * IMG + int'(r_col) + v)];
            w_coef[l*DATA_W +: DATA_W] = r_ker_mem[KAW'(TAPS - 1 - t)];
        end
    end

    assign w_clear      = ((r_state == ST_IDLE) && run) || ((r_state == ST_OUTP) && out_ready);
    assign w_enable     = (r_state == ST_CALC);
    assign w_last_group = (r_tap == TW'(TAPS - LANES));
    assign w_last_pixel = (r_row == OW'(OUT - 1)) && (r_col == OW'(OUT - 1));

    conv_mac_array #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .enable  (w_enable),
        .pix     (w_pix),
        .coef    (w_coef),
        .acc_sum (w_acc_sum)
    );

`ifdef CONV_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'({DATA_W{1'b1}});
    assign w_result = (w_acc_sum > SAT_MAX) ? {DATA_W{1'b1}} : w_acc_sum[DATA_W-1:0];
`else
    logic w_unused_acc_hi;
    assign w_unused_acc_hi = ^w_acc_sum[ACC_W-1:DATA_W];
    assign w_result        = w_acc_sum[DATA_W-1:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_tap       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state <= ST_CALC;
                        r_busy  <= 1'b1;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_tap   <= '0;
                    end
                end
                ST_CALC: begin
                    if (w_last_group) begin
                        // Result presented on the same edge the final taps are summed.
                        r_state     <= ST_OUTP;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_result;
                        r_out_row   <= r_row;
                        r_out_col   <= r_col;
                        r_tap       <= '0;
                    end else begin
                        r_tap <= r_tap + TW'(LANES);
                    end
                end
                ST_OUTP: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last_pixel) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_CALC;
                            if (r_col == OW'(OUT - 1)) begin
                                r_col <= '0;
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_row   = r_out_row;
    assign out_col   = r_out_col;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv2d_stream_engine                                                  |
// | Directed bench: three engines (LANES 3/1/9) sharing one load bus.        |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_conv2d_stream_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_en;
    logic       load_sel;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic       run;
    logic       out_ready;
    logic [1:0] sel;

    logic       run_a   [3];
    logic       valid_a [3];
    logic       busy_a  [3];
    logic       done_a  [3];
    logic [7:0] data_a  [3];
    logic [0:0] row_a   [3];
    logic [0:0] col_a   [3];

    logic       out_valid;
    logic       busy;
    logic       done;
    logic [7:0] out_data;
    logic [0:0] out_row;
    logic [0:0] out_col;

    int n_tests;
    int n_fail;

    int res_d [8];
    int res_r [8];
    int res_c [8];
    int fv    [8];
    int nres, nfv, unstable, ndone, done_cyc, busy_last, timeout;
    int ab_valid, ab_data, ab_row, ab_col, ab_busy, ab_done, ab_after_err;

    int img1 [16] = '{3, 1, 6, 5, 7, 5, 2, 7, 7, 10, 8, 9, 1, 3, 2, 10};
    int ker1 [9]  = '{3, 1, 4, 0, 5, 1, 0, 1, 5};
    int img2 [16] = '{72, 58, 36, 24, 254, 210, 159, 73, 89, 72, 205, 101, 220, 9, 87, 172};
    int ker2 [9]  = '{201, 170, 24, 59, 109, 187, 80, 141, 210};
    int img3 [16] = '{1, 2, 3, 0, 0, 1, 2, 3, 3, 0, 1, 2, 2, 3, 0, 1};
    int ker3 [9]  = '{2, 0, 1, 0, 1, 2, 1, 0, 2};

    always #5 clk = ~clk;

    assign run_a[0] = run && (sel == 2'd0);
    assign run_a[1] = run && (sel == 2'd1);
    assign run_a[2] = run && (sel == 2'd2);

    conv2d_stream_engine #(.DATA_W(8), .IMG(4), .KER(3), .LANES(3)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .run(run_a[0]),
        .busy(busy_a[0]), .done(done_a[0]), .out_valid(valid_a[0]), .out_ready(out_ready),
        .out_data(data_a[0]), .out_row(row_a[0]), .out_col(col_a[0]));

    conv2d_stream_engine #(.DATA_W(8), .IMG(4), .KER(3), .LANES(1)) dut_l1 (
        .clk(clk), .reset(reset), .load_en(load_en), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .run(run_a[1]),
        .busy(busy_a[1]), .done(done_a[1]), .out_valid(valid_a[1]), .out_ready(out_ready),
        .out_data(data_a[1]), .out_row(row_a[1]), .out_col(col_a[1]));

    conv2d_stream_engine #(.DATA_W(8), .IMG(4), .KER(3), .LANES(9)) dut_l9 (
        .clk(clk), .reset(reset), .load_en(load_en), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .run(run_a[2]),
        .busy(busy_a[2]), .done(done_a[2]), .out_valid(valid_a[2]), .out_ready(out_ready),
        .out_data(data_a[2]), .out_row(row_a[2]), .out_col(col_a[2]));

    always_comb begin
        out_valid = valid_a[sel];
        busy      = busy_a[sel];
        done      = done_a[sel];
        out_data  = data_a[sel];
        out_row   = row_a[sel];
        out_col   = col_a[sel];
    end

    task automatic load_frame(input int img [16], input int ker [9]);
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            load_en   = 1'b1;
            load_sel  = (i >= 16);
            load_addr = (i >= 16) ? 4'(i - 16) : 4'(i);
            load_data = (i >= 16) ? 8'(ker[i-16]) : 8'(img[i]);
            @(negedge clk);
        end
        load_en = 1'b0;
    endtask

    // Cycle 0 is the cycle run is high; records handshakes, valid rises, done and busy.
    task automatic drive_frame(input int stall, input int poke, input int abort_cyc);
        int cyc;
        bit prev_valid;
        bit fin;
        int held_d, held_r, held_c;
        nres = 0; nfv = 0; unstable = 0; ndone = 0; done_cyc = -1; busy_last = -1;
        timeout = 0; ab_after_err = 0; cyc = 0; prev_valid = 1'b0; fin = 1'b0;
        held_d = 0; held_r = 0; held_c = 0;
        for (int i = 0; i < 8; i++) fv[i] = -1;
        @(negedge clk);
        run = 1'b1;
        out_ready = 1'b0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            run = 1'b0;
            load_en = 1'b0;
            if (abort_cyc != 0 && cyc == abort_cyc) begin
                reset = 1'b0;
                #1;
                ab_valid = int'(out_valid); ab_data = int'(out_data); ab_row = int'(out_row);
                ab_col = int'(out_col); ab_busy = int'(busy); ab_done = int'(done);
                @(negedge clk);
                reset = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    if (done || busy || out_valid) ab_after_err++;
                    if (done) ndone++;
                    @(negedge clk);
                end
                fin = 1'b1;
            end else begin
                if (out_valid) begin
                    if (!prev_valid) begin
                        if (nfv < 8) fv[nfv] = cyc;
                        nfv++;
                        held_d = int'(out_data); held_r = int'(out_row); held_c = int'(out_col);
                    end else if (int'(out_data) != held_d || int'(out_row) != held_r || int'(out_col) != held_c) begin
                        unstable++;
                    end
                end
                prev_valid = out_valid;
                out_ready = (stall != 0) ? ((cyc % 3) == 0) : 1'b1;
                if (out_valid && out_ready) begin
                    if (nres < 8) begin
                        res_d[nres] = int'(out_data); res_r[nres] = int'(out_row); res_c[nres] = int'(out_col);
                    end
                    nres++;
                end
                if (done) begin ndone++; done_cyc = cyc; end
                if (busy) busy_last = cyc;
                if (poke != 0) begin
                    if (cyc == 3) begin load_en = 1'b1; load_sel = 1'b0; load_addr = 4'd15; load_data = 8'd0; end
                    if (cyc == 10) begin load_en = 1'b1; load_sel = 1'b1; load_addr = 4'd0; load_data = 8'd0; end
                    if (cyc == 6 || cyc == 17) run = 1'b1;
                end
                if (ndone > 0 && cyc >= done_cyc + 2) fin = 1'b1;
                if (cyc >= 300) begin timeout = 1; fin = 1'b1; end
            end
        end
        out_ready = 1'b0;
        run = 1'b0;
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        sel = 2'd0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        n_tests++; if (out_data !== 8'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", out_data); end
        n_tests++; if (out_row !== 1'b0 || out_col !== 1'b0) begin
            n_fail++; $display("FAIL reset_rowcol: got %0d,%0d expected 0,0", out_row, out_col);
        end
    endtask

    task automatic test_basic();
        int exp_d [4] = '{110, 101, 110, 121};
        sel = 2'd0;
        load_frame(img1, ker1);
        drive_frame(0, 0, 0);
        n_tests++; if (timeout !== 0 || nres !== 4) begin n_fail++; $display("FAIL basic_count: got %0d results timeout=%0d expected 4 timeout=0", nres, timeout); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (res_d[i] !== exp_d[i] || res_r[i] !== i / 2 || res_c[i] !== i % 2) begin
                n_fail++; $display("FAIL basic_res%0d: got d=%0d r=%0d c=%0d expected d=%0d r=%0d c=%0d",
                                   i, res_d[i], res_r[i], res_c[i], exp_d[i], i / 2, i % 2);
            end
        end
        n_tests++; if (fv[0] !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d expected 4", fv[0]); end
        n_tests++; if (fv[1] - fv[0] !== 4 || fv[3] !== 16) begin n_fail++; $display("FAIL basic_spacing: got gap=%0d last=%0d expected gap=4 last=16", fv[1] - fv[0], fv[3]); end
        n_tests++; if (ndone !== 1 || done_cyc !== 17) begin n_fail++; $display("FAIL basic_done: got count=%0d cyc=%0d expected count=1 cyc=17", ndone, done_cyc); end
        n_tests++; if (busy_last !== 17) begin n_fail++; $display("FAIL basic_busy: got last busy cyc %0d expected 17", busy_last); end
    endtask

    task automatic test_overflow();
`ifdef CONV_SAT_EN
        int exp_d [4] = '{255, 255, 255, 255};
`else
        int exp_d [4] = '{248, 3, 137, 121};
`endif
        sel = 2'd0;
        load_frame(img2, ker2);
        drive_frame(0, 0, 0);
        n_tests++; if (nres !== 4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", nres); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (res_d[i] !== exp_d[i]) begin
                n_fail++; $display("FAIL ovf_res%0d: got %0d expected %0d", i, res_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_d [4] = '{11, 12, 10, 11};
        sel = 2'd0;
        load_frame(img3, ker3);
        drive_frame(1, 0, 0);
        n_tests++; if (nres !== 4 || timeout !== 0) begin n_fail++; $display("FAIL bp_count: got %0d results timeout=%0d expected 4 timeout=0", nres, timeout); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (res_d[i] !== exp_d[i] || res_r[i] !== i / 2 || res_c[i] !== i % 2) begin
                n_fail++; $display("FAIL bp_res%0d: got d=%0d r=%0d c=%0d expected d=%0d r=%0d c=%0d",
                                   i, res_d[i], res_r[i], res_c[i], exp_d[i], i / 2, i % 2);
            end
        end
        n_tests++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", unstable); end
        n_tests++; if (ndone !== 1) begin n_fail++; $display("FAIL bp_done: got %0d pulses expected 1", ndone); end
    endtask

    task automatic test_lanes();
        int exp_d [4] = '{110, 101, 110, 121};
        int gap;
        load_frame(img1, ker1);
        for (int k = 1; k <= 2; k++) begin
            sel = 2'(k);
            gap = (k == 1) ? 10 : 2;
            drive_frame(0, 0, 0);
            n_tests++; if (nres !== 4) begin n_fail++; $display("FAIL lanes%0d_count: got %0d expected 4", k, nres); end
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (res_d[i] !== exp_d[i]) begin
                    n_fail++; $display("FAIL lanes%0d_res%0d: got %0d expected %0d", k, i, res_d[i], exp_d[i]);
                end
            end
            n_tests++; if (fv[0] !== gap || fv[1] - fv[0] !== gap) begin
                n_fail++; $display("FAIL lanes%0d_timing: got first=%0d gap=%0d expected %0d,%0d", k, fv[0], fv[1] - fv[0], gap, gap);
            end
            n_tests++; if (ndone !== 1 || done_cyc !== 4 * gap + 1) begin
                n_fail++; $display("FAIL lanes%0d_done: got count=%0d cyc=%0d expected 1,%0d", k, ndone, done_cyc, 4 * gap + 1);
            end
        end
        sel = 2'd0;
    endtask

    task automatic test_abort();
        int exp_d [4] = '{110, 101, 110, 121};
        sel = 2'd0;
        drive_frame(0, 0, 8);
        n_tests++; if (nres !== 1 || res_d[0] !== 110) begin n_fail++; $display("FAIL abort_pre: got %0d results first=%0d expected 1,110", nres, res_d[0]); end
        n_tests++; if (ab_valid !== 0 || ab_busy !== 0 || ab_done !== 0) begin
            n_fail++; $display("FAIL abort_ctrl: got valid=%0d busy=%0d done=%0d expected 0,0,0", ab_valid, ab_busy, ab_done);
        end
        n_tests++; if (ab_data !== 0 || ab_row !== 0 || ab_col !== 0) begin
            n_fail++; $display("FAIL abort_data: got d=%0d r=%0d c=%0d expected 0,0,0", ab_data, ab_row, ab_col);
        end
        n_tests++; if (ndone !== 0 || ab_after_err !== 0) begin n_fail++; $display("FAIL abort_quiet: got done=%0d activity=%0d expected 0,0", ndone, ab_after_err); end
        drive_frame(0, 0, 0);
        n_tests++; if (nres !== 4 || ndone !== 1) begin n_fail++; $display("FAIL abort_rerun_count: got %0d results %0d done expected 4,1", nres, ndone); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (res_d[i] !== exp_d[i]) begin
                n_fail++; $display("FAIL abort_rerun_res%0d: got %0d expected %0d", i, res_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int exp_d [4] = '{110, 101, 110, 121};
        sel = 2'd0;
        for (int pass = 0; pass < 2; pass++) begin
            drive_frame(0, (pass == 0) ? 1 : 0, 0);
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (res_d[i] !== exp_d[i]) begin
                    n_fail++; $display("FAIL busyign%0d_res%0d: got %0d expected %0d", pass, i, res_d[i], exp_d[i]);
                end
            end
            n_tests++; if (nres !== 4 || fv[0] !== 4 || fv[3] !== 16) begin
                n_fail++; $display("FAIL busyign%0d_timing: got n=%0d first=%0d last=%0d expected 4,4,16", pass, nres, fv[0], fv[3]);
            end
            n_tests++; if (ndone !== 1 || done_cyc !== 17 || busy_last !== 17) begin
                n_fail++; $display("FAIL busyign%0d_done: got count=%0d cyc=%0d busy_last=%0d expected 1,17,17", pass, ndone, done_cyc, busy_last);
            end
        end
    endtask

    initial begin
        reset = 1'b0; load_en = 1'b0; load_sel = 1'b0; load_addr = 4'd0; load_data = 8'd0;
        run = 1'b0; out_ready = 1'b0; sel = 2'd0;
        n_tests = 0; n_fail = 0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_basic();
        test_overflow();
        test_backpressure();
        test_lanes();
        test_abort();
        test_busy_ignore();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
